// File: rtl/sinc_code_top.sv
// sinc_code_top: repetition-period sync generator with a binary phase-coded pulse.
//
// A free-running counter spans one pulse repetition time (i_prt clocks). For the
// first i_period clocks of every repetition o_sinc is high. While o_sinc is high,
// o_signal plays the phase code in i_codigo MSB-first, one chip every i_tb clocks,
// as +AMP for a 1 bit and -AMP for a 0 bit. Once all chips are played, o_signal
// stays 0 until the window closes.
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst     asynchronous active-low reset
//   i_start   1 = run the repetition cycle, 0 = idle
//   i_prt     pulse repetition time in clocks
//   i_period  sync-pulse width in clocks
//   i_codigo  phase code bits, chip 0 = bit i_numdig-1
//   i_numdig  number of chips (1..32; 0 = silent; >32 clamps to 32)
//   i_tb      chip duration in clocks (0 behaves as 1)
//   o_sinc    transmit window / sync pulse
//   o_signal  signed coded baseband sample
module sinc_code_top #(
  parameter logic signed [15:0] AMP = 16'sd32767
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic        [31:0] i_prt,
  input  logic        [31:0] i_period,
  input  logic        [31:0] i_codigo,
  input  logic        [31:0] i_numdig,
  input  logic        [31:0] i_tb,
  output logic               o_sinc,
  output logic signed [15:0] o_signal
);

  localparam logic signed [15:0] AmpNeg = -AMP;

  logic        [31:0] prt_cnt_q, prt_cnt_d;
  logic        [31:0] tb_cnt_q, tb_cnt_d;
  // idx[5] set means every chip has been played (also covers i_numdig = 0).
  logic        [5:0]  idx_q, idx_d;
  logic               sinc_q, sinc_d;
  logic signed [15:0] signal_q, signal_d;

  logic        [31:0] tb_eff;
  logic        [5:0]  idx_init;

  always_comb begin
    tb_eff   = (i_tb == 32'd0) ? 32'd1 : i_tb;
    // i_numdig = 0 wraps to 6'h3F, which is the "done" marker.
    idx_init = (i_numdig > 32'd32) ? 6'd31 : (i_numdig[5:0] - 6'd1);
  end

  // Repetition counter and sync window.
  always_comb begin
    prt_cnt_d = prt_cnt_q + 32'd1;
    if (!i_start) begin
      prt_cnt_d = 32'd0;
    end else if ((i_prt <= 32'd1) || (prt_cnt_q >= i_prt - 32'd1)) begin
      // >= so that shrinking i_prt below the current count still wraps.
      prt_cnt_d = 32'd0;
    end
    sinc_d = i_start && (prt_cnt_q < i_period);
  end

  // Chip sequencer, driven from the registered window so o_signal lags o_sinc by 1.
  always_comb begin
    tb_cnt_d = 32'd0;
    idx_d    = idx_q;
    signal_d = 16'sd0;
    if (!sinc_q) begin
      idx_d = idx_init;
    end else begin
      if (!idx_q[5]) begin
        signal_d = i_codigo[idx_q[4:0]] ? AMP : AmpNeg;
      end
      if (tb_cnt_q >= tb_eff - 32'd1) begin
        tb_cnt_d = 32'd0;
        if (!idx_q[5]) begin
          idx_d = idx_q - 6'd1;
        end
      end else begin
        tb_cnt_d = tb_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      prt_cnt_q <= 32'd0;
      tb_cnt_q  <= 32'd0;
      idx_q     <= 6'd0;
      sinc_q    <= 1'b0;
      signal_q  <= 16'sd0;
    end else begin
      prt_cnt_q <= prt_cnt_d;
      tb_cnt_q  <= tb_cnt_d;
      idx_q     <= idx_d;
      sinc_q    <= sinc_d;
      signal_q  <= signal_d;
    end
  end

  assign o_sinc   = sinc_q;
  assign o_signal = signal_q;

endmodule

// File: tb/tb_sinc_code_top.sv
module tb_sinc_code_top;

  logic               clk;
  logic               rst;
  logic               start;
  logic        [31:0] prt;
  logic        [31:0] period;
  logic        [31:0] codigo;
  logic        [31:0] numdig;
  logic        [31:0] tb_len;
  logic               sinc;
  logic signed [15:0] signal;

  int vectors;
  int miscompares;

  localparam logic [15:0] Pos = 16'h7FFF;
  localparam logic [15:0] Neg = 16'h8001;

  sinc_code_top dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_prt    (prt),
    .i_period (period),
    .i_codigo (codigo),
    .i_numdig (numdig),
    .i_tb     (tb_len),
    .o_sinc   (sinc),
    .o_signal (signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. k = number of rising edges since i_start went high with
  // the block idle; valid while the configuration is held constant.
  function automatic logic m_sinc(int k);
    int pc;
    if (k < 1) return 1'b0;
    pc = (int'(prt) <= 1) ? 0 : ((k - 1) % int'(prt));
    return (pc < int'(period)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic [15:0] m_sig(int k);
    int w;
    int tbe;
    int nd;
    int chip;
    bit cont;
    if (k < 2) return 16'h0000;
    if (!m_sinc(k - 1)) return 16'h0000;
    cont = (int'(prt) <= 1) ? (int'(period) > 0) : (int'(period) >= int'(prt));
    w    = cont ? (k - 2) : ((k - 2) % int'(prt));
    tbe  = (tb_len == 32'd0) ? 1 : int'(tb_len);
    nd   = (numdig > 32'd32) ? 32 : int'(numdig);
    chip = w / tbe;
    if (chip >= nd) return 16'h0000;
    return codigo[nd - 1 - chip] ? Pos : Neg;
  endfunction

  task automatic go_idle(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_cfg(input logic [31:0] p, input logic [31:0] per, input logic [31:0] c,
                         input logic [31:0] nd, input logic [31:0] t);
    prt = p; period = per; codigo = c; numdig = nd; tb_len = t;
  endtask

  task automatic test_reset();
    set_cfg(32'd100, 32'd44, 32'h712, 32'd11, 32'd4);
    rst   = 1'b0;
    start = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== 1'b0 || signal !== 16'sd0) begin
        miscompares++;
        $display("FAIL reset_hold: sinc=%b signal=%h, want 0/0000", sinc, signal);
      end
    end
    rst = 1'b1;
    // Counting from 0 on the first edge after release.
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL reset_release k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
    end
    // Asynchronous assertion mid-cycle.
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (sinc !== 1'b0 || signal !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_async: sinc=%b signal=%h, want 0/0000", sinc, signal);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    go_idle(2);
  endtask

  task automatic test_basic();
    int rises[$];
    logic prev;
    set_cfg(32'd100, 32'd44, 32'h712, 32'd11, 32'd4);
    go_idle(3);
    start = 1'b1;
    prev  = 1'b0;
    for (int k = 1; k <= 305; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL basic k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
      if (k == 2 || k == 5) begin
        vectors++;
        if (signal !== Pos) begin
          miscompares++;
          $display("FAIL basic_chip0 k=%0d: signal=%h, want %h", k, signal, Pos);
        end
      end
      if (k == 14 || k == 45) begin
        vectors++;
        if (signal !== Neg) begin
          miscompares++;
          $display("FAIL basic_chip3_last k=%0d: signal=%h, want %h", k, signal, Neg);
        end
      end
      if (sinc === 1'b1 && prev === 1'b0) rises.push_back(k);
      prev = sinc;
    end
    vectors++;
    if (rises.size() != 4) begin
      miscompares++;
      $display("FAIL basic_rise_count: got %0d rising edges, want 4", rises.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        vectors++;
        if (rises[i] - rises[i-1] != 100) begin
          miscompares++;
          $display("FAIL basic_rise_spacing: got %0d clocks, want 100", rises[i] - rises[i-1]);
        end
      end
    end
    go_idle(3);
  endtask

  task automatic test_tail_zero();
    set_cfg(32'd100, 32'd50, 32'h712, 32'd11, 32'd4);
    go_idle(3);
    start = 1'b1;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL tail k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
      // Window is edges 1..50; chips occupy 2..45; 46..51 must be silent.
      if (k >= 46 && k <= 50) begin
        vectors++;
        if (sinc !== 1'b1 || signal !== 16'sd0) begin
          miscompares++;
          $display("FAIL tail_silent k=%0d: sinc=%b signal=%h, want 1/0000", k, sinc, signal);
        end
      end
    end
    go_idle(3);
  endtask

  task automatic test_start_drop();
    logic [15:0] hold;
    set_cfg(32'd100, 32'd44, 32'h712, 32'd11, 32'd4);
    go_idle(3);
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL drop_pre k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
    end
    hold  = m_sig(21);
    start = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (sinc !== 1'b0 || signal !== hold) begin
      miscompares++;
      $display("FAIL drop_edge1: sinc=%b signal=%h, want 0/%h", sinc, signal, hold);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (signal !== 16'sd0) begin
      miscompares++;
      $display("FAIL drop_edge2: signal=%h, want 0000", signal);
    end
    go_idle(2);
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL drop_restart k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
    end
    go_idle(3);
  endtask

  task automatic test_tb_zero();
    logic [15:0] want [1:6];
    want[1] = 16'h0000; want[2] = Pos; want[3] = Neg;
    want[4] = Pos;      want[5] = 16'h0000; want[6] = 16'h0000;
    set_cfg(32'd10, 32'd3, 32'b101, 32'd3, 32'd0);
    go_idle(3);
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
        miscompares++;
        $display("FAIL tb0 k=%0d: sinc=%b signal=%h, want %b/%h",
                 k, sinc, signal, m_sinc(k), m_sig(k));
      end
      if (k <= 6) begin
        vectors++;
        if (signal !== want[k]) begin
          miscompares++;
          $display("FAIL tb0_fixed k=%0d: signal=%h, want %h", k, signal, want[k]);
        end
      end
    end
    go_idle(3);
  endtask

  task automatic test_random();
    int n;
    for (int t = 0; t < 10; t++) begin
      prt    = $urandom_range(60, 2);
      period = $urandom_range(int'(prt) + 5, 0);
      codigo = $urandom;
      numdig = $urandom_range(40, 0);
      tb_len = $urandom_range(5, 0);
      go_idle(3);
      vectors++;
      if (sinc !== 1'b0 || signal !== 16'sd0) begin
        miscompares++;
        $display("FAIL rand_idle t=%0d: sinc=%b signal=%h, want 0/0000", t, sinc, signal);
      end
      n = 2 * int'(prt) + 10;
      start = 1'b1;
      for (int k = 1; k <= n; k++) begin
        @(posedge clk);
        #1;
        vectors++;
        if (sinc !== m_sinc(k) || signal !== m_sig(k)) begin
          miscompares++;
          $display("FAIL rand t=%0d k=%0d prt=%0d per=%0d nd=%0d tb=%0d: sinc=%b signal=%h, want %b/%h",
                   t, k, prt, period, numdig, tb_len, sinc, signal, m_sinc(k), m_sig(k));
        end
      end
    end
    go_idle(3);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    set_cfg(32'd100, 32'd44, 32'h712, 32'd11, 32'd4);
    #1;
    test_reset();
    test_basic();
    test_tail_zero();
    test_start_drop();
    test_tb_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
